// File: rtl/tdm_demux_1x4_if.sv
// Sample-stream and lane-output bundle for tdm_demux_1x4; parity signals exist only with TDM_DEMUX_PARITY_EN.
// Pure wiring, no latency; no backpressure (the demux accepts every beat).
// master = upstream link driving beats, slave = the demux.
interface tdm_demux_1x4_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic [WIDTH-1:0]          in_data;
    logic                      in_valid;
    logic                      in_sync;
    logic                      in_err_clr;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_valid;
    logic                      out_frame;
    logic                      out_locked;
    logic                      out_sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic                      in_parity;
    logic                      out_parity_err;

    modport master (
        output in_data, in_valid, in_sync, in_err_clr, in_parity,
        input  out_data, out_valid, out_frame, out_locked, out_sync_err, out_parity_err
    );
    modport slave (
        input  in_data, in_valid, in_sync, in_err_clr, in_parity,
        output out_data, out_valid, out_frame, out_locked, out_sync_err, out_parity_err
    );
`else
    modport master (
        output in_data, in_valid, in_sync, in_err_clr,
        input  out_data, out_valid, out_frame, out_locked, out_sync_err
    );
    modport slave (
        input  in_data, in_valid, in_sync, in_err_clr,
        output out_data, out_valid, out_frame, out_locked, out_sync_err
    );
`endif
endinterface

// File: rtl/tdm_demux_1x4.sv
// TDM receive demux: steers sync-aligned samples into CHANNELS registered lanes, tracks lock; TDM_DEMUX_PARITY_EN adds even-parity checking.
// Latency: one cycle, beat sampled at edge N appears on its lane, strobe and frame pulse after edge N.
// Backpressure: none, every valid beat is consumed in the cycle it arrives.
module tdm_demux_1x4 #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic            in_clk,
    input  logic            in_rst_n,
    tdm_demux_1x4_if.slave  bus
);
    localparam int SW = $clog2(CHANNELS);
    localparam logic [SW-1:0] SLOT_LAST = SW'(CHANNELS - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

    typedef enum logic {ST_HUNT, ST_LOCKED} state_e;

    state_e                    state_q, state_d;
    logic [SW-1:0]             slot_q, slot_d;
    logic                      frame_ok_q, frame_ok_d;
    logic [CHANNELS*WIDTH-1:0] data_q, data_d;
    logic [CHANNELS-1:0]       valid_q, valid_d;
    logic                      frame_q, frame_d;
    logic                      sync_err_q, sync_err_d;

    logic                      beat_ok;
    logic                      wr_en;
    logic [SW-1:0]             wr_lane;
    logic                      last_beat;
    logic                      sync_set;
    logic                      par_set;

`ifdef TDM_DEMUX_PARITY_EN
    logic                      parity_err_q, parity_err_d;

    assign beat_ok = ~(^{bus.in_data, bus.in_parity});
`else
    assign beat_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        frame_ok_d = frame_ok_q;
        data_d     = data_q;
        valid_d    = '0;
        frame_d    = 1'b0;
        wr_en      = 1'b0;
        wr_lane    = '0;
        last_beat  = 1'b0;
        sync_set   = 1'b0;
        par_set    = 1'b0;

        if (bus.in_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (bus.in_sync) begin
                        wr_en      = 1'b1;
                        slot_d     = SLOT_ONE;
                        frame_ok_d = 1'b1;
                        state_d    = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (bus.in_sync) begin
                        // Sync anywhere restarts the frame; off slot 0 it is also an alignment error.
                        sync_set   = (slot_q != '0);
                        wr_en      = 1'b1;
                        slot_d     = SLOT_ONE;
                        frame_ok_d = 1'b1;
                    end else if (slot_q == '0) begin
                        sync_set = 1'b1;
                        state_d  = ST_HUNT;
                    end else begin
                        wr_en   = 1'b1;
                        wr_lane = slot_q;
                        if (slot_q == SLOT_LAST) begin
                            slot_d    = '0;
                            last_beat = 1'b1;
                        end else begin
                            slot_d = slot_q + SLOT_ONE;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase

            // A corrupt beat keeps its slot but never lands in the lane and spoils the frame.
            if (wr_en) begin
                if (beat_ok) begin
                    data_d[int'(wr_lane)*WIDTH +: WIDTH] = bus.in_data;
                    valid_d[wr_lane]                     = 1'b1;
                end else begin
                    frame_ok_d = 1'b0;
                    par_set    = 1'b1;
                end
            end
            frame_d = last_beat & frame_ok_q & beat_ok;
        end

        sync_err_d = sync_set | (sync_err_q & ~bus.in_err_clr);
`ifdef TDM_DEMUX_PARITY_EN
        parity_err_d = par_set | (parity_err_q & ~bus.in_err_clr);
`endif
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q      <= ST_HUNT;
            slot_q       <= '0;
            frame_ok_q   <= 1'b0;
            data_q       <= '0;
            valid_q      <= '0;
            frame_q      <= 1'b0;
            sync_err_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            frame_ok_q   <= frame_ok_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_q      <= frame_d;
            sync_err_q   <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.out_data     = data_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_frame    = frame_q;
    assign bus.out_locked   = (state_q == ST_LOCKED);
    assign bus.out_sync_err = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign bus.out_parity_err = parity_err_q;
`endif
endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Time-division demultiplexer: the receive end of a TDM channel mux. Takes one shared sample stream and steers successive samples into CHANNELS registered output lanes.
- Frame alignment comes from a sync flag on the channel-0 slot.
- Sits after a TDM serializer/link, in front of per-channel consumers.
- Tracks frame lock, flags sync errors and signals frame completion.

Parameters:
- WIDTH, 8, bits per sample.
- CHANNELS, 4, number of output lanes. Legal range 2..16. Slot counter width is $clog2(CHANNELS).

Ports:
- in_clk  input  1  sole clock; rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  sample for the current slot.
- in_valid  input  1  in_data is a beat this cycle.
- in_sync  input  1  qualified by in_valid; marks the channel-0 slot.
- in_err_clr  input  1  synchronous clear of the sticky error flags.
- out_data  output  CHANNELS*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]; registered; holds its last value.
- out_valid  output  CHANNELS  one-cycle strobe for lane k when lane k is updated.
- out_frame  output  1  one-cycle pulse when a complete aligned frame has been delivered.
- out_locked  output  1  high in the LOCKED state.
- out_sync_err  output  1  sticky alignment-error flag.

Behaviour:
- Reset (async, in_rst_n=0): all outputs are 0, out_data is 0, slot is 0, state is HUNT. Deassertion takes effect on the next in_clk edge.
- States:
  - HUNT: beats with in_sync=0 are discarded. A beat with in_sync=1 writes lane 0 and sets slot=1, then goes to LOCKED.
  - LOCKED, valid beat at slot s≠0, in_sync=0: write lane s, s=s+1. At s=CHANNELS-1, s wraps to 0 and out_frame pulses.
  - LOCKED, valid beat at slot 0, in_sync=1: write lane 0, s=1. This is normal frame start.
  - LOCKED, valid beat at slot 0, in_sync=0: loss of lock. Discard the beat, set out_sync_err, go to HUNT.
  - LOCKED, valid beat at slot s≠0, in_sync=1: early sync. Set out_sync_err, treat the beat as lane 0 (write lane 0, s=1) and stay LOCKED. The partial frame never produces out_frame.
- in_valid=0: no state or slot change, and all strobes are 0. Gaps of any length are legal between beats.
- Latency: the beat is sampled at edge N. out_data lane, out_valid[k] and out_frame are visible after edge N and last exactly one cycle, with no combinational in→out path.
- out_frame asserts together with out_valid[CHANNELS-1] for the final beat of the frame. out_frame only follows a frame that started with a sync beat and had no error within it.
- At most one out_valid bit is high in any cycle.
- out_locked is registered and reflects the state after the edge.
- Sticky flags:
  - If in_err_clr and a new error occur in the same cycle, set wins.
  - in_err_clr does not affect state, slot or data.
- Asynchronous reset mid-frame discards the partial frame. No out_frame is produced for it.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- When defined:
  - Adds input in_parity (1 bit). Even parity applies: ^{in_data,in_parity} must be 0.
  - Adds output out_parity_err (1 bit, sticky, reset 0, cleared by in_err_clr with set-wins).
  - On a parity-failing valid beat, the slot still advances and state transitions apply as normal. The lane register is not written, its out_valid bit is suppressed, out_parity_err is set, and out_frame is suppressed for that frame.
- When not defined: neither port exists and all beats are accepted.

Test Plan:
- Reset then frame: sync beat 0x11, then 0x22, 0x33, 0x44 on consecutive cycles -> out_valid 0001,0010,0100,1000. out_frame=1 with the last strobe. out_data=0x44332211. out_locked=1.
- Gapped beats: same frame with 3 idle cycles between each beat -> identical outputs. No strobes during gaps. Single out_frame.
- Early sync: sync 0xA0, 0xA1, then sync 0xB0, 0xB1, 0xB2, 0xB3 -> out_sync_err=1, lane0=0xB0, exactly one out_frame (after 0xB3), still locked.
- Lock loss: after a full frame, a slot-0 beat 0x55 with in_sync=0 -> beat dropped, out_locked=0, out_sync_err=1. Following non-sync beats are ignored until a sync beat arrives. Pulse in_err_clr -> out_sync_err=0.
- Reset mid-frame: assert in_rst_n=0 after 2 beats -> all outputs 0 immediately (asynchronously). The next sync-started frame delivers normally.
- (TDM_DEMUX_PARITY_EN) frame with a bad parity bit on slot 2 -> out_valid[2] never asserts, lane 2 keeps its old value, out_parity_err=1, no out_frame. The next clean frame produces out_frame.
